hqm_aw_bindec_buf: RTL
======================

// Module: hqm_aw_bindec_buf
// PURPOSE
//  Registered binary-to-one-hot decoder with valid/ready flow control; the inverse of the AW priority
//  encoder. Takes an encoded bit index and returns the WIDTH-bit one-hot vector with that bit set.
//  Sits where an encoded selection (arbiter winner, free-slot index) must be re-expanded into a
//  per-slot strobe vector. Includes a 2-entry skid buffer so in_ready is a register.
// PARAMETERS
//  WIDTH   2       decoded vector width; must be >1 (initial assertion, $stop unless +AW_CONTINUE_ON_ERROR)
//  EWIDTH  AW_logb2(WIDTH-1)+1  encoded index width (derived; do not override)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset: synchronous, active-high
//  in_v         in   1       input index valid
//  in_ready     out  1       buffer can accept; registered
//  in_enc       in   EWIDTH  encoded bit index
//  in_en        in   1       decode enable; 0 -> all-zero vector delivered for this beat
//  out_v        out  1       output beat valid
//  out_ready    in   1       downstream accepts
//  out_dec      out  WIDTH   one-hot (or zero) decoded vector
//  out_enc      out  EWIDTH  index echoed with out_dec
//  err_oor      out  1       1-cycle pulse: an accepted index was >= WIDTH
//  err_oor_stk  out  1       sticky out-of-range flag; cleared only by rst
// BEHAVIOUR
//  - Accept: in_v & in_ready. Deliver: out_v & out_ready.
//  - Decode at acceptance: dec = (in_en & in_enc<WIDTH) ? (1<<in_enc) : '0. Store dec + enc.
//  - Storage: 2 entries, head/tail pointers, count 0..2. States EMPTY(0), ONE(1), FULL(2).
//  - EMPTY: accept -> ONE. ONE: accept only -> FULL; deliver only -> EMPTY; both -> ONE.
//  - FULL: deliver -> ONE; no accept is possible in FULL.
//  - in_ready = (count!=2), from a flop updated with next count. Deassert in the cycle after the accept that fills.
//  - out_v = (count!=0). out_dec/out_enc driven from the head entry.
//  - Latency: an accepted beat is visible on out_v in the next cycle. No combinational in->out path.
//  - out_dec/out_enc hold stable while out_v & !out_ready (no change under backpressure).
//  - Ordering: strict FIFO; no bypass, no reordering.
//  - Out-of-range: in_enc >= WIDTH (possible only when WIDTH is not a power of 2). The beat is still
//    accepted and delivered with out_dec='0. err_oor pulses 1 cycle after acceptance; err_oor_stk set.
//  - in_en=0 with out-of-range in_enc: zero vector delivered; error flags still fire.
//  - in_v while !in_ready: ignored. The source must hold in_v/in_enc/in_en stable until accepted.
//  - Reset (rst=1 any cycle, incl. mid-transfer): count=0 and pointers=0. Stored beats are dropped.
//    out_v=0, in_ready=0 while rst=1, in_ready=1 the first cycle after rst falls. out_dec='0, out_enc='0.
//    err_oor=0, err_oor_stk=0.
//  - Pointer wrap: 1-bit head/tail toggle at entry 1 -> 0.
// TESTING (WIDTH=6, EWIDTH=3 unless noted)
//  1. rst 3 cycles, then in_v=1 enc=3 en=1, out_ready=1.
//     -> out_v=1 next cycle, out_dec=6'b001000, out_enc=3; in_ready stays 1.
//  2. out_ready=0; send enc=0, then enc=5.
//     -> in_ready=0 after 2nd accept. out_dec holds 6'b000001 until out_ready=1, then 6'b100000. No loss.
//  3. Stream enc 0..5 back-to-back, out_ready toggling 1/0 each cycle.
//     -> out_dec sequence 000001..100000 in order; pointers wrap and count never exceeds 2.
//  4. enc=6 (then enc=7) en=1.
//     -> delivered with out_dec=6'b000000. err_oor pulses 1 cycle per beat; err_oor_stk=1 until rst.
//  5. enc=2 en=0.
//     -> out_dec=6'b000000, out_enc=2, no error.
//     WIDTH=8 enc=7 -> out_dec=8'h80, no error.
//  6. FULL with out_ready=0, assert rst 1 cycle.
//     -> out_v=0 and in_ready=0 during rst; in_ready=1 after; stored beats never appear.

Source files
------------

// File: rtl/hqm_aw_bindec_buf.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer.
// The index is decoded at acceptance; beats leave in strict FIFO order.
module hqm_aw_bindec_buf #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned EWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_v,
  output logic              in_ready,
  input  logic [EWIDTH-1:0] in_enc,
  input  logic              in_en,
  output logic              out_v,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_dec,
  output logic [EWIDTH-1:0] out_enc,
  output logic              err_oor,
  output logic              err_oor_stk
);

  localparam logic [EWIDTH:0] WIDTH_E = (EWIDTH+1)'(WIDTH);

  if (WIDTH < 2) begin : g_width_chk
    $error("hqm_aw_bindec_buf: WIDTH must be greater than 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic              head_q;
  logic              tail_q;
  logic              head_nxt;
  logic              tail_nxt;
  logic [WIDTH-1:0]  dec_mem [2];
  logic [EWIDTH-1:0] enc_mem [2];

  logic              accept_c;
  logic              deliver_c;
  logic              oor_c;
  logic [WIDTH-1:0]  dec_c;
  logic [WIDTH-1:0]  head_dec_c;
  logic [EWIDTH-1:0] head_enc_c;

  assign accept_c  = in_v & in_ready;
  assign deliver_c = out_v & out_ready;

  // Decode of the incoming index; out-of-range indices produce no set bit.
  always_comb begin
    oor_c = ({1'b0, in_enc} >= WIDTH_E);
    dec_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dec_c[i] = in_en & (in_enc == EWIDTH'(i));
    end
  end

  // Occupancy FSM plus pointer and next-head selection.
  always_comb begin
    state_nxt = state_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    unique case (state_q)
      EMPTY: if (accept_c) state_nxt = ONE;
      ONE: begin
        if (accept_c && !deliver_c)      state_nxt = FULL;
        else if (!accept_c && deliver_c) state_nxt = EMPTY;
      end
      FULL:    if (deliver_c) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (accept_c)  tail_nxt = ~tail_q;
    if (deliver_c) head_nxt = ~head_q;
    // A beat written this cycle into the slot that becomes head must be forwarded.
    if (accept_c && (tail_q == head_nxt)) begin
      head_dec_c = dec_c;
      head_enc_c = in_enc;
    end else begin
      head_dec_c = dec_mem[head_nxt];
      head_enc_c = enc_mem[head_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      in_ready    <= 1'b0;
      out_v       <= 1'b0;
      out_dec     <= '0;
      out_enc     <= '0;
      err_oor     <= 1'b0;
      err_oor_stk <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      head_q      <= head_nxt;
      tail_q      <= tail_nxt;
      in_ready    <= (state_nxt != FULL);
      out_v       <= (state_nxt != EMPTY);
      out_dec     <= head_dec_c;
      out_enc     <= head_enc_c;
      err_oor     <= accept_c & oor_c;
      err_oor_stk <= err_oor_stk | (accept_c & oor_c);
    end
  end

  // Storage entries carry no reset; validity comes from the occupancy state.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      dec_mem[tail_q] <= dec_c;
      enc_mem[tail_q] <= in_enc;
    end
  end

endmodule
